// File: rtl/bram_mm_master_if.sv
// Command / write-stream / read-stream / BRAM s1 signal bundle for bram_mm_master.
// Stats outputs exist only when BRAM_MM_MASTER_STATS_EN is defined.
interface bram_mm_master_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 10
);
  localparam int unsigned BeW = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic [BeW-1:0]    wr_be;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  logic              busy;
  logic              done;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_clken;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [BeW-1:0]    mem_byteenable;
  logic [DATA_W-1:0] mem_readdata;

`ifdef BRAM_MM_MASTER_STATS_EN
  logic [31:0]       stat_wr_words;
  logic [31:0]       stat_rd_words;
`endif

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data, wr_be,
    input  rd_ready, mem_readdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
    output mem_address, mem_clken, mem_chipselect, mem_write, mem_writedata, mem_byteenable
`ifdef BRAM_MM_MASTER_STATS_EN
    , output stat_wr_words, stat_rd_words
`endif
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data, wr_be,
    output rd_ready, mem_readdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
    input  mem_address, mem_clken, mem_chipselect, mem_write, mem_writedata, mem_byteenable
`ifdef BRAM_MM_MASTER_STATS_EN
    , input stat_wr_words, stat_rd_words
`endif
  );
endinterface

// File: rtl/bram_mm_master.sv
// Avalon-MM style BRAM initiator: one command becomes a run of single-word accesses, with
// read data returned in order through a credit-protected FIFO. Optional: BRAM_MM_MASTER_STATS_EN.
module bram_mm_master #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LEN_W        = 10,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic              clk,
  input logic              reset_n,
  bram_mm_master_if.master bus
);
  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [LEN_W-1:0]        remain_q, remain_d;
  logic                    mem_cs_q, mem_cs_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic [BeW-1:0]          mem_be_q, mem_be_d;
  logic                    wr_last_q, wr_last_d;
  logic                    done_q, done_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]         wptr_q, rptr_q;
  logic [CntW-1:0]         count_q, count_d;
  logic [CntW-1:0]         inflight;
  logic                    rd_pres;
  logic                    rd_valid_s;
  logic                    push, pop, issue_ok;

  assign rd_pres    = mem_cs_q & ~mem_we_q;
  assign push       = vld_q[READ_LATENCY-1];
  assign rd_valid_s = (count_q != '0);
  assign pop        = rd_valid_s & bus.rd_ready;

  // Reads on the bus or in the latency pipe, all of which will land in the FIFO.
  always_comb begin
    inflight = CntW'(rd_pres);
    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      inflight = inflight + CntW'(vld_q[i]);
    end
  end

  // Crediting the same-cycle pop keeps 1 word/cycle when rd_ready is held high.
  assign issue_ok = (SumW'(count_q) + SumW'(inflight)) < (SumW'(FIFO_DEPTH) + SumW'(pop));

  always_comb begin
    vld_d[0] = rd_pres;
    for (int i = 1; i < int'(READ_LATENCY); i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  assign count_d = count_q + CntW'(push) - CntW'(pop);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    wr_last_d   = 1'b0;
    done_d      = wr_last_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          addr_d   = bus.cmd_addr;
          remain_d = bus.cmd_len;
          state_d  = bus.cmd_write ? StWrite : StRead;
        end
      end
      StWrite: begin
        if (bus.wr_valid) begin
          mem_cs_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = bus.wr_data;
          mem_be_d    = bus.wr_be;
          addr_d      = addr_q + ADDR_W'(1);
          if (remain_q == '0) begin
            wr_last_d = 1'b1;
            state_d   = StIdle;
          end else begin
            remain_d = remain_q - LEN_W'(1);
          end
        end
      end
      StRead: begin
        if (issue_ok) begin
          mem_cs_d   = 1'b1;
          mem_addr_d = addr_q;
          mem_be_d   = '1;
          addr_d     = addr_q + ADDR_W'(1);
          if (remain_q == '0) begin
            state_d = StDrain;
          end else begin
            remain_d = remain_q - LEN_W'(1);
          end
        end
      end
      StDrain: begin
        // Last word is landing in the FIFO when it is the only one still outstanding.
        if (push && (inflight == CntW'(1))) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remain_q    <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      wr_last_q   <= 1'b0;
      done_q      <= 1'b0;
      vld_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wr_last_q   <= wr_last_d;
      done_q      <= done_d;
      vld_q       <= vld_d;
      count_q     <= count_d;
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= bus.mem_readdata;
  end

  assign bus.cmd_ready      = reset_n & (state_q == StIdle);
  assign bus.wr_ready       = (state_q == StWrite);
  assign bus.rd_valid       = rd_valid_s;
  assign bus.rd_data        = rd_valid_s ? fifo_mem[rptr_q] : '0;
  assign bus.busy           = (state_q != StIdle);
  assign bus.done           = done_q;
  assign bus.mem_address    = mem_addr_q;
  assign bus.mem_clken      = reset_n;
  assign bus.mem_chipselect = mem_cs_q;
  assign bus.mem_write      = mem_we_q;
  assign bus.mem_writedata  = mem_wdata_q;
  assign bus.mem_byteenable = mem_be_q;

`ifdef BRAM_MM_MASTER_STATS_EN
  logic [31:0] stat_wr_q, stat_rd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else begin
      if (mem_cs_q && mem_we_q && (stat_wr_q != '1)) stat_wr_q <= stat_wr_q + 32'd1;
      if (pop && (stat_rd_q != '1))                  stat_rd_q <= stat_rd_q + 32'd1;
    end
  end

  assign bus.stat_wr_words = stat_wr_q;
  assign bus.stat_rd_words = stat_rd_q;
`endif
endmodule

// File: tb/tb_bram_mm_master.sv
// Directed self-checking bench for bram_mm_master with a 2-cycle-latency BRAM model.
module tb_bram_mm_master;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 10;
  localparam int unsigned RL = 2;
  localparam int unsigned FD = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bram_mm_master_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  bram_mm_master #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // BRAM model: data for a read presented in cycle C is on mem_readdata during cycle C+2.
  logic [31:0] ram [1024];
  logic [31:0] rd_s1 = 32'h0;
  logic [31:0] rd_s2 = 32'h0;
  initial for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
  always @(posedge clk) begin
    logic [31:0] m;
    if (bus.mem_clken && bus.mem_chipselect) begin
      m = ram[bus.mem_address];
      if (bus.mem_write) begin
        for (int b = 0; b < 4; b++) if (bus.mem_byteenable[b]) m[b*8 +: 8] = bus.mem_writedata[b*8 +: 8];
        ram[bus.mem_address] <= m;
      end
      rd_s1 <= ram[bus.mem_address];
    end
    rd_s2 <= rd_s1;
  end
  assign bus.mem_readdata = rd_s2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0]  wa_log[$];
  logic [31:0] wd_log[$];
  logic [3:0]  wb_log[$];
  int          wc_log[$];
  logic [31:0] rd_log[$];
  int          rc_log[$];
  int done_cnt = 0, done_cyc = 0, acc_cyc = 0, first_rdv = -1;
  int issued = 0, popped = 0, max_occ = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc + 1;
      if (bus.mem_chipselect && bus.mem_write) begin
        wa_log.push_back(bus.mem_address);
        wd_log.push_back(bus.mem_writedata);
        wb_log.push_back(bus.mem_byteenable);
        wc_log.push_back(cyc);
      end
      if (bus.mem_chipselect && !bus.mem_write) issued++;
      if (issued - popped > max_occ) max_occ = issued - popped;
      if (bus.rd_valid && first_rdv < 0) first_rdv = cyc;
      if (bus.rd_valid && bus.rd_ready) begin
        rd_log.push_back(bus.rd_data);
        rc_log.push_back(cyc);
        popped++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [9:0] a, input logic [9:0] len);
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !bus.cmd_ready; i++) tick();
    check("cmd_ready_wait", 128'(bus.cmd_ready), 128'(1));
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  logic [31:0] wq[$];
  logic [3:0]  bq[$];

  task automatic write_burst(input logic [9:0] a);
    int beats = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = wq[0];
    bus.wr_be    = bq[0];
    send_cmd(1'b1, a, 10'(wq.size() - 1));
    for (int g = 0; g < 60 && beats < wq.size(); g++) begin
      logic acc;
      bus.wr_data = wq[beats];
      bus.wr_be   = bq[beats];
      acc = bus.wr_ready;
      tick();
      if (acc) beats++;
    end
    bus.wr_valid = 1'b0;
    check("wr_beats", 128'(beats), 128'(wq.size()));
    repeat (3) tick();
  endtask

  task automatic wait_rd(input int n, input int bound);
    for (int i = 0; i < bound && rd_log.size() < n; i++) tick();
  endtask

  task automatic clear_logs();
    wa_log.delete(); wd_log.delete(); wb_log.delete(); wc_log.delete();
    rd_log.delete(); rc_log.delete();
    done_cnt = 0; first_rdv = -1;
  endtask

  function automatic logic [127:0] outs();
    return 128'({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.busy, bus.done,
                 bus.mem_address, bus.mem_clken, bus.mem_chipselect, bus.mem_write,
                 bus.mem_writedata, bus.mem_byteenable});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.wr_be = '0; bus.rd_ready = 1'b1;

    // Reset held for 5 cycles with random inputs.
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = 1'($urandom); bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = 10'($urandom); bus.cmd_len = 10'($urandom);
      bus.wr_valid  = 1'($urandom); bus.wr_data = 32'($urandom);
      bus.wr_be     = 4'($urandom); bus.rd_ready = 1'($urandom);
      tick();
      check("reset_outputs", outs(), 128'(0));
    end
    bus.cmd_valid = 1'b0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b1;
    reset_n = 1'b1;
    #1;
    check("cmd_ready_after_reset", 128'(bus.cmd_ready), 128'(1));
    check("clken_after_reset", 128'(bus.mem_clken), 128'(1));
    tick();

    // Write 4 words at 0x010.
    clear_logs();
    wq = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    bq = '{4'hF, 4'hF, 4'hF, 4'hF};
    write_burst(10'h010);
    for (int i = 0; i < 4; i++) check("wr_addr", 128'(wa_log[i]), 128'(10'h010 + 10'(i)));
    check("wr_data_last", 128'(wd_log[3]), 128'(32'h44444444));
    check("wr_first_latency", 128'(wc_log[0] - acc_cyc), 128'(1));
    check("wr_rate", 128'(wc_log[3] - wc_log[0]), 128'(3));
    check("wr_done_count", 128'(done_cnt), 128'(1));
    check("wr_done_timing", 128'(done_cyc - wc_log[3]), 128'(1));

    // Read them back.
    clear_logs();
    send_cmd(1'b0, 10'h010, 10'd3);
    wait_rd(4, 40);
    repeat (4) tick();
    check("rd_count", 128'(rd_log.size()), 128'(4));
    for (int i = 0; i < 4; i++) check("rd_data", 128'(rd_log[i]), 128'(32'h11111111 * (i + 1)));
    check("rd_latency", 128'(first_rdv - acc_cyc), 128'(RL + 2));
    check("rd_rate", 128'(rc_log[3] - rc_log[0]), 128'(3));
    check("rd_done_count", 128'(done_cnt), 128'(1));
    check("idle_after_read", 128'(bus.busy), 128'(0));

    // Address wrap.
    clear_logs();
    wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    bq = '{4'hF, 4'hF, 4'hF, 4'hF};
    write_burst(10'h3FE);
    check("wrap_a0", 128'(wa_log[0]), 128'(10'h3FE));
    check("wrap_a1", 128'(wa_log[1]), 128'(10'h3FF));
    check("wrap_a2", 128'(wa_log[2]), 128'(10'h000));
    check("wrap_a3", 128'(wa_log[3]), 128'(10'h001));

    // Byte enables.
    wq = '{32'h0}; bq = '{4'hF};
    write_burst(10'h020);
    clear_logs();
    wq = '{32'hAABBCCDD}; bq = '{4'b0101};
    write_burst(10'h020);
    check("be_on_bus", 128'(wb_log[0]), 128'(4'b0101));
    check("be_wdata", 128'(wd_log[0]), 128'(32'hAABBCCDD));
    clear_logs();
    send_cmd(1'b0, 10'h020, 10'd0);
    wait_rd(1, 30);
    check("be_readback", 128'(rd_log[0]), 128'(32'h00BB00DD));

    // Backpressure: 16-word read with rd_ready low for 20 cycles.
    wq.delete(); bq.delete();
    for (int i = 0; i < 16; i++) begin
      wq.push_back(32'hBEEF0000 | 32'(i));
      bq.push_back(4'hF);
    end
    write_burst(10'h100);
    clear_logs();
    issued = 0; popped = 0; max_occ = 0;
    bus.rd_ready = 1'b0;
    send_cmd(1'b0, 10'h100, 10'd15);
    repeat (20) tick();
    check("bp_no_pop", 128'(rd_log.size()), 128'(0));
    check("bp_issued_stall", 128'(issued), 128'(FD));
    check("bp_rd_valid", 128'(bus.rd_valid), 128'(1));
    bus.rd_ready = 1'b1;
    wait_rd(16, 80);
    repeat (4) tick();
    check("bp_count", 128'(rd_log.size()), 128'(16));
    for (int i = 0; i < 16; i++) check("bp_data", 128'(rd_log[i]), 128'(32'hBEEF0000 | 32'(i)));
    check("bp_max_occ", 128'(max_occ), 128'(FD));
    check("bp_done_count", 128'(done_cnt), 128'(1));

    // Reset during word 3 of an 8-word read.
    clear_logs();
    send_cmd(1'b0, 10'h100, 10'd7);
    for (int i = 0; i < 40 && rd_log.size() < 3; i++) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_outputs", outs(), 128'(0));
    tick();
    reset_n = 1'b1;
    #1;
    check("midrst_cmd_ready", 128'(bus.cmd_ready), 128'(1));
    check("midrst_rd_valid", 128'(bus.rd_valid), 128'(0));
    tick();
    clear_logs();
    send_cmd(1'b0, 10'h010, 10'd1);
    wait_rd(2, 40);
    repeat (8) tick();
    check("post_rst_count", 128'(rd_log.size()), 128'(2));
    check("post_rst_w0", 128'(rd_log[0]), 128'(32'h11111111));
    check("post_rst_w1", 128'(rd_log[1]), 128'(32'h22222222));
    check("post_rst_done", 128'(done_cnt), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
